golden_nonce_chk: RTL and testbench

// - Downstream consumer of the nonce generator and the SHA-256d core.
// - Pops one 256-bit digest from the hashout FIFO (HASH_WORDS x 64-bit words) and the matching nonce from the nonce FIFO.
// - Compares the digest against the software target; writes the nonce of every digest <= target into the result FIFO.
// - Keeps a checked-hash count and a golden-nonce count for software polling.

---
 rtl/golden_nonce_chk.sv | 144 ++++++++++++++
 tb/tb_golden_nonce_chk.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_chk.sv
// rtl/golden_nonce_chk.sv - assembles digests from the hashout FIFO, compares them to the target and forwards golden nonces
module golden_nonce_chk #(
  parameter int HASH_WORDS = 4,
  parameter int GOLD_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [64*HASH_WORDS-1:0]   target,
  input  logic                       hashout_fifo_empty,
  input  logic [63:0]                hashout_fifo_dout,
  output logic                       hashout_fifo_re,
  input  logic                       nonce_fifo_empty,
  input  logic [31:0]                nonce_fifo_dout,
  output logic                       nonce_fifo_re,
  input  logic                       result_fifo_full,
  output logic                       result_fifo_we,
  output logic [31:0]                result_fifo_din,
  output logic [31:0]                hash_cnt,
  output logic [GOLD_CNT_W-1:0]      golden_cnt,
  output logic                       stop_ack_chk
);

  localparam int HW     = 64 * HASH_WORDS;
  localparam int WIDX_W = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_NONCE,
    S_COMPARE,
    S_WRITE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WIDX_W-1:0]   w_idx;
  logic [HW-1:0]       hash_reg;
  logic [HW-1:0]       target_reg;
  logic [31:0]         nonce_reg;
  logic                stop_pend;

  logic                stop_exit;
  logic                last_word;
  logic                golden;
  logic                start_ok;

  // A stop is honoured only between hashes, i.e. before the first word of a new digest is popped.
  assign stop_exit = (w_idx == '0) && stop_pend;
  assign last_word = (w_idx == WIDX_W'(HASH_WORDS - 1));
  assign golden    = (hash_reg <= target_reg);
  assign start_ok  = start && !stop;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; empty/full flags stall the current state indefinitely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (stop_exit) begin
          state_nxt = S_IDLE;
        end else if (!hashout_fifo_empty && last_word) begin
          state_nxt = S_NONCE;
        end
      end
      S_NONCE:   if (!nonce_fifo_empty) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = golden ? S_WRITE : S_COLLECT;
      S_WRITE:   if (!result_fifo_full) state_nxt = S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FIFO handshakes are combinational so a word is consumed in the same cycle it is seen.
  always_comb begin
    hashout_fifo_re = 1'b0;
    nonce_fifo_re   = 1'b0;
    result_fifo_we  = 1'b0;
    case (state)
      S_COLLECT: hashout_fifo_re = !stop_exit && !hashout_fifo_empty;
      S_NONCE:   nonce_fifo_re   = !nonce_fifo_empty;
      S_WRITE:   result_fifo_we  = !result_fifo_full;
      default:   ;
    endcase
  end

  assign result_fifo_din = nonce_reg;

  // Datapath: digest shift register, nonce/target latches, counters and the stop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx        <= '0;
      hash_reg     <= '0;
      target_reg   <= '0;
      nonce_reg    <= '0;
      hash_cnt     <= '0;
      golden_cnt   <= '0;
      stop_pend    <= 1'b0;
      stop_ack_chk <= 1'b0;
    end else begin
      stop_ack_chk <= (state_nxt == S_IDLE);

      if (state == S_IDLE) begin
        stop_pend <= 1'b0;
      end else begin
        stop_pend <= stop_pend | stop;
      end

      if (state == S_IDLE && start_ok) begin
        target_reg <= target;
        hash_cnt   <= '0;
        golden_cnt <= '0;
        w_idx      <= '0;
      end

      if (hashout_fifo_re) begin
        hash_reg <= {hash_reg[HW-65:0], hashout_fifo_dout};
        w_idx    <= last_word ? '0 : w_idx + 1'b1;
      end

      if (nonce_fifo_re) begin
        nonce_reg <= nonce_fifo_dout;
      end

      if (state == S_COMPARE) begin
        hash_cnt <= hash_cnt + 32'd1;
      end

      if (result_fifo_we && (golden_cnt != '1)) begin
        golden_cnt <= golden_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_golden_nonce_chk.sv
// tb/tb_golden_nonce_chk.sv - directed bench for golden_nonce_chk with FWFT FIFO models
module tb_golden_nonce_chk;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [255:0]  target;
  logic          hashout_fifo_empty;
  logic [63:0]   hashout_fifo_dout;
  logic          hashout_fifo_re;
  logic          nonce_fifo_empty;
  logic [31:0]   nonce_fifo_dout;
  logic          nonce_fifo_re;
  logic          result_fifo_full;
  logic          result_fifo_we;
  logic [31:0]   result_fifo_din;
  logic [31:0]   hash_cnt;
  logic [15:0]   golden_cnt;
  logic          stop_ack_chk;

  golden_nonce_chk #(.HASH_WORDS(4), .GOLD_CNT_W(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .stop               (stop),
    .target             (target),
    .hashout_fifo_empty (hashout_fifo_empty),
    .hashout_fifo_dout  (hashout_fifo_dout),
    .hashout_fifo_re    (hashout_fifo_re),
    .nonce_fifo_empty   (nonce_fifo_empty),
    .nonce_fifo_dout    (nonce_fifo_dout),
    .nonce_fifo_re      (nonce_fifo_re),
    .result_fifo_full   (result_fifo_full),
    .result_fifo_we     (result_fifo_we),
    .result_fifo_din    (result_fifo_din),
    .hash_cnt           (hash_cnt),
    .golden_cnt         (golden_cnt),
    .stop_ack_chk       (stop_ack_chk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] hq[$];
  logic [31:0] nq[$];
  logic [31:0] res[$];
  logic [31:0] exp_res[$];
  int          total = 0;
  int          bad   = 0;
  int          viol  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic void refresh();
    hashout_fifo_empty = (hq.size() == 0);
    hashout_fifo_dout  = hashout_fifo_empty ? 64'h0 : hq[0];
    nonce_fifo_empty   = (nq.size() == 0);
    nonce_fifo_dout    = nonce_fifo_empty ? 32'h0 : nq[0];
  endfunction

  // FIFO models: sample handshakes at the edge, update contents just after it.
  always @(posedge clk) begin
    logic hre, nre, we;
    logic [31:0] din;
    hre = hashout_fifo_re;
    nre = nonce_fifo_re;
    we  = result_fifo_we;
    din = result_fifo_din;
    if (hre && hashout_fifo_empty) viol++;
    if (nre && nonce_fifo_empty)   viol++;
    if (we && result_fifo_full)    viol++;
    #1;
    if (hre && hq.size() > 0) void'(hq.pop_front());
    if (nre && nq.size() > 0) void'(nq.pop_front());
    if (we) res.push_back(din);
    refresh();
  end

  task automatic push_hash(input logic [255:0] d);
    hq.push_back(d[255:192]);
    hq.push_back(d[191:128]);
    hq.push_back(d[127:64]);
    hq.push_back(d[63:0]);
    refresh();
  endtask

  task automatic push_nonce(input logic [31:0] n);
    nq.push_back(n);
    refresh();
  endtask

  task automatic do_start(input logic [255:0] t, input logic with_stop);
    @(negedge clk);
    target = t;
    start  = 1'b1;
    stop   = with_stop;
    @(negedge clk);
    start  = 1'b0;
    stop   = 1'b0;
    target = '0;
  endtask

  task automatic do_stop(input string tag);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 50 && !stop_ack_chk; i++) @(negedge clk);
    chk(tag, stop_ack_chk, 1);
  endtask

  task automatic wait_hash(input string tag, input int n);
    for (int i = 0; i < 300 && hash_cnt != n; i++) @(negedge clk);
    chk(tag, hash_cnt, n);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_res(input string tag);
    chk({tag, "_n"}, res.size(), exp_res.size());
    for (int i = 0; i < exp_res.size(); i++) begin
      chk($sformatf("%s_%0d", tag, i), (i < res.size()) ? res[i] : 32'hdead_beef, exp_res[i]);
    end
    res.delete();
    exp_res.delete();
  endtask

  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] T2   = {64'h0000_0000_FFFF_0000, 192'h0};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; target = '0; result_fifo_full = 1'b0;
    refresh();
    repeat (3) @(negedge clk);
    chk("rst_ack", stop_ack_chk, 0);
    chk("rst_hash_cnt", hash_cnt, 0);
    chk("rst_gold_cnt", golden_cnt, 0);
    chk("rst_we", result_fifo_we, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ack_after_rst", stop_ack_chk, 1);

    // all-ones target: every digest is golden
    do_start(ONES, 1'b0);
    chk("ack_busy", stop_ack_chk, 0);
    push_hash({4{64'h0123_4567_89ab_cdef}}); push_nonce(5);
    push_hash(ONES);                          push_nonce(6);
    push_hash(256'h0);                        push_nonce(7);
    wait_hash("t1_hash_cnt", 3);
    chk("t1_gold_cnt", golden_cnt, 3);
    exp_res.push_back(5); exp_res.push_back(6); exp_res.push_back(7);
    chk_res("t1_res");
    do_stop("t1_stop_ack");

    // threshold target with boundary digests
    do_start(T2, 1'b0);
    push_hash(T2);                                           push_nonce(9);
    push_hash({64'h0000_0001_0000_0000, 192'h0});            push_nonce(10);
    wait_hash("t2_hash_cnt", 2);
    chk("t2_gold_cnt", golden_cnt, 1);
    push_hash({64'h0000_0000_FFFF_0000, 192'h1});            push_nonce(11);
    push_hash({64'h0000_0000_FFFE_FFFF, {192{1'b1}}});       push_nonce(12);
    wait_hash("t2b_hash_cnt", 4);
    chk("t2b_gold_cnt", golden_cnt, 2);
    exp_res.push_back(9); exp_res.push_back(12);
    chk_res("t2_res");
    do_stop("t2_stop_ack");

    // hashout FIFO runs dry between words 1 and 2
    do_start({64'h1, 64'h2, 64'h3, 64'h4}, 1'b0);
    hq.push_back(64'h1); hq.push_back(64'h2); push_nonce(32'h33);
    repeat (20) @(negedge clk);
    chk("t3_stall_cnt", hash_cnt, 0);
    chk("t3_stall_res", res.size(), 0);
    chk("t3_stall_nq", nq.size(), 1);
    hq.push_back(64'h3); hq.push_back(64'h4); refresh();
    wait_hash("t3_hash_cnt", 1);
    exp_res.push_back(32'h33);
    chk_res("t3_res");
    do_stop("t3_stop_ack");

    // result FIFO full while a golden nonce is waiting
    result_fifo_full = 1'b1;
    do_start(ONES, 1'b0);
    push_hash(256'h5); push_nonce(32'h55);
    push_hash(256'h6); push_nonce(32'h56);
    repeat (16) @(negedge clk);
    chk("t4_full_res", res.size(), 0);
    chk("t4_full_hq", hq.size(), 4);
    chk("t4_full_cnt", hash_cnt, 1);
    chk("t4_full_we", result_fifo_we, 0);
    result_fifo_full = 1'b0;
    #1;
    chk("t4_we_release", result_fifo_we, 1);
    wait_hash("t4_hash_cnt", 2);
    chk("t4_gold_cnt", golden_cnt, 2);
    exp_res.push_back(32'h55); exp_res.push_back(32'h56);
    chk_res("t4_res");
    do_stop("t4_stop_ack");

    // stop after the first word of a golden digest
    do_start(ONES, 1'b0);
    hq.push_back(64'hA); refresh();
    for (int i = 0; i < 20 && hq.size() != 0; i++) @(negedge clk);
    stop = 1'b1;
    hq.push_back(64'hB); hq.push_back(64'hC); hq.push_back(64'hD);
    push_nonce(32'h42);
    push_hash(256'h7); push_nonce(32'h43);
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 50 && !stop_ack_chk; i++) @(negedge clk);
    chk("t5_stop_ack", stop_ack_chk, 1);
    repeat (5) @(negedge clk);
    chk("t5_hq_left", hq.size(), 4);
    chk("t5_nq_left", nq.size(), 1);
    chk("t5_hash_cnt", hash_cnt, 1);
    chk("t5_gold_cnt", golden_cnt, 1);
    exp_res.push_back(32'h42);
    chk_res("t5_res");

    // start together with stop is ignored
    do_start(ONES, 1'b1);
    repeat (8) @(negedge clk);
    chk("t6_ack", stop_ack_chk, 1);
    chk("t6_hq_left", hq.size(), 4);
    chk("t6_hash_cnt", hash_cnt, 1);
    chk("t6_res", res.size(), 0);

    chk("protocol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
